// File: rtl/i2c_reg_target.sv
// i2c_reg_target: SCL-synchronous I2C-style target with a small register file.
// A frame is a start bit, then a 7-bit address and R/W bit. The first data
// byte loads the register pointer. Each later byte writes reg[ptr], and the
// pointer auto-increments after the write.
// Optional read path: define I2C_TGT_READ_EN. Without it, an address match
// with R/W=1 is not acknowledged and the target skips the frame.
//
// state | meaning
// IDLE  | line idle, waiting for start bit (SDA_IN=0)
// ADDR  | shifting address + R/W byte
// ACK   | driving ACK low for one slot
// CONT  | sampling continue bit (0 = another byte, 1 = end)
// DATA  | shifting a data byte (pointer or register write)
// SKIP  | not addressed; wait for IDLE_RUN consecutive 1 samples
// TX    | driving reg[ptr] MSB first (read build only)
// MACK  | master ACK/NACK slot after a read byte (read build only)
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter int         REG_AW   = 2,
  parameter int         IDLE_RUN = 12
) (
  input  logic              SCL,
  input  logic              rst,
  input  logic              SDA_IN,
  output logic              SDA_OUT,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              addr_match
);

  localparam int DEPTH = 2 ** REG_AW;
  localparam int RUN_W = $clog2(IDLE_RUN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK, S_CONT, S_DATA, S_SKIP, S_TX, S_MACK
  } state_t;

  state_t            state;
  logic [7:0]        regs [DEPTH];
  logic [REG_AW-1:0] ptr;
  logic [6:0]        shift;
  logic [2:0]        bit_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              first_byte;
  logic [7:0]        rx_byte;
  logic              dev_hit;

  // Byte completed by the bit sampled on this edge.
  assign rx_byte = {shift, SDA_IN};
  assign dev_hit = (rx_byte[7:1] == DEV_ADDR);
  assign rd_data = regs[rd_addr];
  assign busy    = (state != S_IDLE);

`ifdef I2C_TGT_READ_EN
  logic       rd_mode;
  logic [7:0] cur_reg;
  logic [2:0] tx_idx;
  assign cur_reg = regs[ptr];
  assign tx_idx  = bit_cnt - 3'd1;
`endif

  // Frame sequencer, register file and registered outputs.
  always_ff @(posedge SCL) begin
    if (rst) begin
      state      <= S_IDLE;
      SDA_OUT    <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      addr_match <= 1'b0;
      ptr        <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      run_cnt    <= '0;
      first_byte <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
`ifdef I2C_TGT_READ_EN
      rd_mode    <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!SDA_IN) begin
            state   <= S_ADDR;
            bit_cnt <= '0;
          end
        end
        S_ADDR: begin
          shift   <= {shift[5:0], SDA_IN};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (dev_hit && !rx_byte[0]) begin
              SDA_OUT    <= 1'b0;
              addr_match <= 1'b1;
              first_byte <= 1'b1;
              state      <= S_ACK;
`ifdef I2C_TGT_READ_EN
              rd_mode    <= 1'b0;
            end else if (dev_hit && rx_byte[0]) begin
              SDA_OUT    <= 1'b0;
              addr_match <= 1'b1;
              rd_mode    <= 1'b1;
              state      <= S_ACK;
`endif
            end else begin
              run_cnt <= RUN_W'(IDLE_RUN);
              state   <= S_SKIP;
            end
          end
        end
        S_ACK: begin
`ifdef I2C_TGT_READ_EN
          if (rd_mode) begin
            SDA_OUT <= cur_reg[7];
            bit_cnt <= 3'd7;
            state   <= S_TX;
          end else begin
            SDA_OUT <= 1'b1;
            state   <= S_CONT;
          end
`else
          SDA_OUT <= 1'b1;
          state   <= S_CONT;
`endif
        end
        S_CONT: begin
          if (SDA_IN) begin
            addr_match <= 1'b0;
            state      <= S_IDLE;
          end else begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          shift   <= {shift[5:0], SDA_IN};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            SDA_OUT <= 1'b0;
            state   <= S_ACK;
            if (first_byte) begin
              ptr        <= rx_byte[REG_AW-1:0];
              first_byte <= 1'b0;
            end else begin
              wr_en     <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
              regs[ptr] <= rx_byte;
              ptr       <= ptr + REG_AW'(1);
            end
          end
        end
        S_SKIP: begin
          if (!SDA_IN) run_cnt <= RUN_W'(IDLE_RUN);
          else if (run_cnt == RUN_W'(1)) state <= S_IDLE;
          else run_cnt <= run_cnt - RUN_W'(1);
        end
`ifdef I2C_TGT_READ_EN
        S_TX: begin
          if (bit_cnt == 3'd0) begin
            SDA_OUT <= 1'b1;
            ptr     <= ptr + REG_AW'(1);
            state   <= S_MACK;
          end else begin
            SDA_OUT <= cur_reg[tx_idx];
            bit_cnt <= tx_idx;
          end
        end
        S_MACK: begin
          if (!SDA_IN) begin
            SDA_OUT <= cur_reg[7];
            bit_cnt <= 3'd7;
            state   <= S_TX;
          end else begin
            addr_match <= 1'b0;
            state      <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed testbench for i2c_reg_target (default parameters).
// Inputs change on negedge SCL; outputs are sampled 2 time units after posedge.
module tb_i2c_reg_target;

  logic       SCL = 1'b0;
  logic       rst = 1'b1;
  logic       SDA_IN = 1'b1;
  logic       SDA_OUT, wr_en, busy, addr_match;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int low_cnt = 0;
  logic [1:0] log_a [8];
  logic [7:0] log_d [8];

  i2c_reg_target dut (
    .SCL(SCL), .rst(rst), .SDA_IN(SDA_IN), .SDA_OUT(SDA_OUT),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .addr_match(addr_match)
  );

  always #5 SCL = ~SCL;

  // Log write pulses and count cycles with SDA_OUT driven low.
  always @(posedge SCL) begin
    #1;
    if (wr_en === 1'b1) begin
      if (wr_cnt < 8) begin
        log_a[wr_cnt] = wr_addr;
        log_d[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (SDA_OUT === 1'b0) low_cnt++;
  end

  task automatic clk_bit(input logic b);
    @(negedge SCL);
    SDA_IN = b;
    @(posedge SCL);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i]);
  endtask

  task automatic start_addr(input logic [6:0] a, input logic rw);
    clk_bit(1'b0);
    send_byte({a, rw});
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw,
                            output logic lo, output logic rel);
    start_addr(a, rw);
    lo = SDA_OUT;
    clk_bit(1'b1);
    rel = SDA_OUT;
  endtask

  // Continue bit 0, byte, ACK slot.
  task automatic data_byte(input logic [7:0] d, output logic lo, output logic rel,
                           output logic we, output logic we_after);
    clk_bit(1'b0);
    send_byte(d);
    lo = SDA_OUT;
    we = wr_en;
    clk_bit(1'b1);
    rel = SDA_OUT;
    we_after = wr_en;
  endtask

  task automatic test_reset;
    @(negedge SCL); rst = 1'b1; SDA_IN = 1'b1;
    @(posedge SCL); #2;
    checks++; if (SDA_OUT !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", SDA_OUT); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (wr_addr !== 2'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL reset_addr_match: got %b expected 0", addr_match); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h expected 00", i, rd_data); end
    end
    @(negedge SCL); rst = 1'b0;
  endtask

  task automatic test_idle_hold;
    logic saw_busy, saw_low;
    saw_busy = 1'b0; saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      clk_bit(1'b1);
      if (busy !== 1'b0) saw_busy = 1'b1;
      if (SDA_OUT !== 1'b1) saw_low = 1'b1;
    end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", saw_busy); end
    checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL idle_sda: got %b expected 0", saw_low); end
  endtask

  task automatic test_single_write;
    logic lo, rel, we, wa;
    wr_cnt = 0; low_cnt = 0;
    addr_phase(7'h21, 1'b0, lo, rel);
    checks++; if (lo !== 1'b0) begin errors++; $display("FAIL sw_addr_ack: got %b expected 0", lo); end
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL sw_addr_release: got %b expected 1", rel); end
    checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL sw_addr_match: got %b expected 1", addr_match); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy: got %b expected 1", busy); end
    data_byte(8'h02, lo, rel, we, wa);
    checks++; if (lo !== 1'b0) begin errors++; $display("FAIL sw_ptr_ack: got %b expected 0", lo); end
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL sw_ptr_release: got %b expected 1", rel); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL sw_ptr_no_write: got %b expected 0", we); end
    data_byte(8'hA5, lo, rel, we, wa);
    checks++; if (lo !== 1'b0) begin errors++; $display("FAIL sw_data_ack: got %b expected 0", lo); end
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL sw_data_release: got %b expected 1", rel); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_wr_en: got %b expected 1", we); end
    checks++; if (wa !== 1'b0) begin errors++; $display("FAIL sw_wr_en_single: got %b expected 0", wa); end
    checks++; if (wr_addr !== 2'd2) begin errors++; $display("FAIL sw_wr_addr: got %h expected 2", wr_addr); end
    checks++; if (wr_data !== 8'hA5) begin errors++; $display("FAIL sw_wr_data: got %h expected a5", wr_data); end
    clk_bit(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_end: got %b expected 0", busy); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL sw_match_end: got %b expected 0", addr_match); end
    rd_addr = 2'd2; #1;
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL sw_rd_data: got %h expected a5", rd_data); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL sw_wr_count: got %0d expected 1", wr_cnt); end
    checks++; if (low_cnt !== 3) begin errors++; $display("FAIL sw_low_cycles: got %0d expected 3", low_cnt); end
  endtask

  task automatic test_burst_wrap;
    logic lo, rel, we, wa;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h22; exp_rd[1] = 8'h33; exp_rd[2] = 8'hA5; exp_rd[3] = 8'h11;
    wr_cnt = 0; low_cnt = 0;
    addr_phase(7'h21, 1'b0, lo, rel);
    data_byte(8'h03, lo, rel, we, wa);
    data_byte(8'h11, lo, rel, we, wa);
    data_byte(8'h22, lo, rel, we, wa);
    data_byte(8'h33, lo, rel, we, wa);
    clk_bit(1'b1);
    checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL bw_wr_count: got %0d expected 3", wr_cnt); end
    checks++; if (log_a[0] !== 2'd3 || log_d[0] !== 8'h11) begin errors++; $display("FAIL bw_write0: got %h/%h expected 3/11", log_a[0], log_d[0]); end
    checks++; if (log_a[1] !== 2'd0 || log_d[1] !== 8'h22) begin errors++; $display("FAIL bw_write1: got %h/%h expected 0/22", log_a[1], log_d[1]); end
    checks++; if (log_a[2] !== 2'd1 || log_d[2] !== 8'h33) begin errors++; $display("FAIL bw_write2: got %h/%h expected 1/33", log_a[2], log_d[2]); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== exp_rd[i]) begin errors++; $display("FAIL bw_reg%0d: got %h expected %h", i, rd_data, exp_rd[i]); end
    end
    checks++; if (low_cnt !== 5) begin errors++; $display("FAIL bw_low_cycles: got %0d expected 5", low_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bw_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_addr_mismatch;
    logic lo, rel, we, wa;
    wr_cnt = 0; low_cnt = 0;
    start_addr(7'h22, 1'b0);
    checks++; if (SDA_OUT !== 1'b1) begin errors++; $display("FAIL mm_no_ack: got %b expected 1", SDA_OUT); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL mm_addr_match: got %b expected 0", addr_match); end
    repeat (5) clk_bit(1'b1);
    clk_bit(1'b0);
    repeat (11) clk_bit(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mm_busy_after_11: got %b expected 1", busy); end
    clk_bit(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy_after_12: got %b expected 0", busy); end
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL mm_low_cycles: got %0d expected 0", low_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL mm_wr_count: got %0d expected 0", wr_cnt); end
    addr_phase(7'h21, 1'b0, lo, rel);
    checks++; if (lo !== 1'b0) begin errors++; $display("FAIL mm_next_ack: got %b expected 0", lo); end
    data_byte(8'h01, lo, rel, we, wa);
    data_byte(8'h5A, lo, rel, we, wa);
    clk_bit(1'b1);
    checks++; if (wr_cnt !== 1 || log_a[0] !== 2'd1 || log_d[0] !== 8'h5A) begin errors++; $display("FAIL mm_next_write: got %0d %h/%h expected 1 1/5a", wr_cnt, log_a[0], log_d[0]); end
    rd_addr = 2'd1; #1;
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL mm_next_reg1: got %h expected 5a", rd_data); end
  endtask

  task automatic test_reset_mid_frame;
    logic lo, rel, we, wa;
    addr_phase(7'h21, 1'b0, lo, rel);
    data_byte(8'h00, lo, rel, we, wa);
    clk_bit(1'b0);
    clk_bit(1'b1); clk_bit(1'b0); clk_bit(1'b1); clk_bit(1'b0);
    @(negedge SCL); rst = 1'b1; SDA_IN = 1'b1;
    @(posedge SCL); #2;
    checks++; if (SDA_OUT !== 1'b1) begin errors++; $display("FAIL mr_sda: got %b expected 1", SDA_OUT); end
    checks++; if (wr_addr !== 2'd0 || wr_data !== 8'h00 || wr_en !== 1'b0) begin errors++; $display("FAIL mr_wr_port: got %b %h/%h expected 0 0/00", wr_en, wr_addr, wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b expected 0", busy); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL mr_addr_match: got %b expected 0", addr_match); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mr_reg%0d: got %h expected 00", i, rd_data); end
    end
    @(negedge SCL); rst = 1'b0;
    repeat (2) clk_bit(1'b1);
    test_single_write();
    rd_addr = 2'd1; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mr_reg1_cleared: got %h expected 00", rd_data); end
  endtask

  task automatic test_read;
    logic lo, rel, we, wa;
    logic [7:0] exp_b;
    exp_b = 8'h3C;
    addr_phase(7'h21, 1'b0, lo, rel);
    data_byte(8'h00, lo, rel, we, wa);
    data_byte(8'h3C, lo, rel, we, wa);
    clk_bit(1'b1);
    addr_phase(7'h21, 1'b0, lo, rel);
    data_byte(8'h00, lo, rel, we, wa);
    clk_bit(1'b1);
    rd_addr = 2'd0; #1;
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL rd_setup_reg0: got %h expected 3c", rd_data); end
    wr_cnt = 0; low_cnt = 0;
    start_addr(7'h21, 1'b1);
`ifdef I2C_TGT_READ_EN
    checks++; if (SDA_OUT !== 1'b0) begin errors++; $display("FAIL rd_ack: got %b expected 0", SDA_OUT); end
    checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL rd_addr_match: got %b expected 1", addr_match); end
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1);
      checks++; if (SDA_OUT !== exp_b[i]) begin errors++; $display("FAIL rd_bit%0d: got %b expected %b", i, SDA_OUT, exp_b[i]); end
    end
    clk_bit(1'b1);
    checks++; if (SDA_OUT !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rd_mack_slot: got sda %b busy %b expected 1 1", SDA_OUT, busy); end
    clk_bit(1'b1);
    checks++; if (busy !== 1'b0 || addr_match !== 1'b0) begin errors++; $display("FAIL rd_nack_idle: got busy %b match %b expected 0 0", busy, addr_match); end
`else
    checks++; if (SDA_OUT !== 1'b1) begin errors++; $display("FAIL rd_no_ack: got %b expected 1", SDA_OUT); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rd_addr_match: got %b expected 0", addr_match); end
    repeat (12) clk_bit(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_skip_idle: got %b expected 0", busy); end
    checks++; if (low_cnt !== 0) begin errors++; $display("FAIL rd_low_cycles: got %0d expected 0", low_cnt); end
`endif
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rd_no_writes: got %0d expected 0", wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_single_write();
    test_burst_wrap();
    test_addr_mismatch();
    test_reset_mid_frame();
    test_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
